// File: rtl/cycle_sequencer_pkg.sv
// rtl/cycle_sequencer_pkg.sv - shared widths and state encoding for the cycle sequencer
package cycle_sequencer_pkg;

  localparam int DEF_FAST_COUNT_WIDTH = 5;
  localparam int DEF_N_CYCLES_WIDTH   = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_CLEAR = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - arms, clears and runs an external cycle counter for n_cycles periods
// Outputs are registered from the next state so they align with the state they describe.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int FAST_COUNT_WIDTH = DEF_FAST_COUNT_WIDTH,
  parameter int N_CYCLES_WIDTH   = DEF_N_CYCLES_WIDTH
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        trigger,
  input  logic                        abort,
  input  logic [FAST_COUNT_WIDTH-1:0] period,
  input  logic [N_CYCLES_WIDTH-1:0]   n_cycles,
  input  logic                        end_cycle,
  output logic                        sclr,
  output logic                        clken,
  output logic [FAST_COUNT_WIDTH-1:0] count_max,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted,
  output logic [N_CYCLES_WIDTH-1:0]   cycles_done
);

  localparam logic [N_CYCLES_WIDTH-1:0] ONE = N_CYCLES_WIDTH'(1);

  logic [2:0]                state;
  logic [2:0]                state_nxt;
  logic [N_CYCLES_WIDTH-1:0] n_reg;
  logic                      accept;
  logic                      abort_hit;
  logic                      count_hit;
  logic                      last_cycle;

  assign accept     = (state == ST_IDLE) && start && !abort;
  assign abort_hit  = abort && ((state == ST_ARMED) || (state == ST_CLEAR) || (state == ST_RUN));
  assign count_hit  = (state == ST_RUN) && end_cycle && !abort;
  // n_reg is at least 1 whenever RUN is reachable, so +1 cannot overflow here
  assign last_cycle = count_hit && ((cycles_done + ONE) == n_reg);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (n_cycles == '0) ? ST_DONE : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (trigger) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: state_nxt = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (last_cycle) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      sclr    <= 1'b0;
      clken   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_nxt;
      sclr    <= (state_nxt == ST_CLEAR);
      clken   <= (state_nxt == ST_RUN);
      busy    <= (state_nxt != ST_IDLE);
      done    <= (state_nxt == ST_DONE);
      aborted <= abort_hit;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_max   <= '0;
      n_reg       <= '0;
      cycles_done <= '0;
    end else if (accept) begin
      count_max   <= period;
      n_reg       <= n_cycles;
      cycles_done <= '0;
    end else if (count_hit && (cycles_done != n_reg)) begin
      cycles_done <= cycles_done + ONE;
    end
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - randomized scoreboard bench for cycle_sequencer
module tb_cycle_sequencer;
  import cycle_sequencer_pkg::*;

  localparam int FW = 5;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          trigger = 1'b0;
  logic          abort = 1'b0;
  logic [FW-1:0] period = '0;
  logic [NW-1:0] n_cycles = '0;
  logic          end_cycle;
  logic          sclr, clken, busy, done, aborted;
  logic [FW-1:0] count_max;
  logic [NW-1:0] cycles_done;

  always #5 clk = ~clk;

  cycle_sequencer #(.FAST_COUNT_WIDTH(FW), .N_CYCLES_WIDTH(NW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .trigger(trigger), .abort(abort),
    .period(period), .n_cycles(n_cycles), .end_cycle(end_cycle),
    .sclr(sclr), .clken(clken), .count_max(count_max), .busy(busy),
    .done(done), .aborted(aborted), .cycles_done(cycles_done)
  );

  // The cycle counter that sits beside the sequencer in the real system
  logic [FW-1:0] fast_cnt = '0;
  logic          ec_noise = 1'b0;
  always @(posedge clk) begin
    if (sclr) fast_cnt <= '0;
    else if (clken) fast_cnt <= (fast_cnt == count_max) ? '0 : fast_cnt + FW'(1);
  end
  assign end_cycle = (clken && (fast_cnt == count_max)) || ec_noise;

  typedef struct {
    bit is_abort;
    int cycles;
    int cmax;
    int sclr_n;
    int clken_n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  bit   mon_flush = 1'b0;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endfunction

  // Monitor: pops one expectation per done/aborted pulse
  initial begin
    exp_t e;
    int   sclr_seen = 0;
    int   clken_seen = 0;
    bit   post_evt = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_flush) begin
        sclr_seen = 0;
        clken_seen = 0;
        mon_flush = 1'b0;
      end
      if (post_evt) begin
        chk("pulse_one_cycle", {30'd0, done, aborted}, 0);
        chk("idle_after_event", busy, 0);
        post_evt = 1'b0;
      end
      if (sclr) sclr_seen++;
      if (clken) clken_seen++;
      if (done || aborted) begin
        chk("event_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("aborted_flag", aborted, e.is_abort);
          chk("done_flag", done, !e.is_abort);
          chk("cycles_done", cycles_done, e.cycles);
          chk("count_max", count_max, e.cmax);
          chk("sclr_cycles", sclr_seen, e.sclr_n);
          chk("clken_cycles", clken_seen, e.clken_n);
        end
        sclr_seen = 0;
        clken_seen = 0;
        post_evt = 1'b1;
      end
    end
  end

  task automatic do_start(int p, int n);
    period = FW'(p);
    n_cycles = NW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int t = 0;
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic idle_gap();
    if ($urandom_range(0, 1) == 1) begin
      abort = 1'b1;
      start = $urandom_range(0, 1) == 1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      chk("idle_abort_no_effect", busy, 0);
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic run_normal(int p, int n, int tdelay, bit start_in_run);
    exp_q.push_back('{1'b0, n, p, 1, n * (p + 1)});
    do_start(p, n);
    chk("busy_after_start", busy, 1);
    repeat (tdelay) begin
      ec_noise = $urandom_range(0, 1) == 1;
      @(negedge clk);
    end
    ec_noise = 1'b0;
    pulse_trigger();
    if (start_in_run) begin
      repeat (2) @(negedge clk);
      do_start(p + 1, n + 3);
    end
    wait_idle(n * (p + 1) + 50);
  endtask

  task automatic run_zero(int p);
    exp_q.push_back('{1'b0, 0, p, 0, 0});
    do_start(p, 0);
    chk("zero_done_latency", done, 1);
    wait_idle(5);
  endtask

  task automatic run_abort_run(int p, int n, int k, int j);
    int cnt = 0;
    int guard = 0;
    exp_q.push_back('{1'b1, k, p, 1, k * (p + 1) + j});
    do_start(p, n);
    pulse_trigger();
    while (cnt < k && guard < 2000) begin
      @(negedge clk);
      if (end_cycle) cnt++;
      guard++;
    end
    chk("abort_pulse_count_reached", cnt, k);
    repeat (j) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(10);
  endtask

  task automatic run_abort_armed(int p, int n, int wait_n);
    exp_q.push_back('{1'b1, 0, p, 0, 0});
    do_start(p, n);
    repeat (wait_n) @(negedge clk);
    trigger = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    abort = 1'b0;
    wait_idle(10);
  endtask

  task automatic run_abort_clear(int p, int n);
    exp_q.push_back('{1'b1, 0, p, 1, 0});
    do_start(p, n);
    pulse_trigger();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(10);
  endtask

  task automatic run_reset_mid();
    do_start(7, 4);
    pulse_trigger();
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_sclr", sclr, 0);
    chk("rst_clken", clken, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count_max", count_max, 0);
    chk("rst_cycles_done", cycles_done, 0);
    chk("rst_pulses", {30'd0, done, aborted}, 0);
    mon_flush = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    trigger = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_stays_idle", busy, 0);
    end
    trigger = 1'b0;
    chk("post_reset_clken", clken, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_sclr", sclr, 0);
    chk("reset_clken", clken, 0);
    chk("reset_count_max", count_max, 0);
    chk("reset_cycles_done", cycles_done, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    run_normal(15, 4, 5, 1'b0);
    idle_gap();
    run_zero(9);
    idle_gap();
    run_abort_run(15, 4, 2, 3);
    idle_gap();
    run_abort_armed(6, 3, 2);
    idle_gap();
    run_abort_clear(5, 2);
    idle_gap();
    run_normal(4, 3, 2, 1'b1);
    idle_gap();
    run_abort_run(3, 3, 1, 4);
    idle_gap();
    run_reset_mid();
    idle_gap();

    for (int s = 0; s < 30; s++) begin
      int kind = $urandom_range(0, 5);
      int p = $urandom_range(3, 15);
      int n = $urandom_range(2, 5);
      case (kind)
        0: run_normal(p, $urandom_range(1, 5), $urandom_range(0, 6), 1'b0);
        1: run_zero(p);
        2: run_abort_run(p, n, $urandom_range(1, n - 1), $urandom_range(1, p + 1));
        3: run_abort_armed(p, n, $urandom_range(0, 3));
        4: run_abort_clear(p, n);
        default: run_normal(p, n, $urandom_range(0, 4), 1'b1);
      endcase
      idle_gap();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
